// File: rtl/axil_credit_pkg.sv
// axil_credit_pkg: shared AXI-Lite/NBF widths and the beat count used by the credit/word counter.
package axil_credit_pkg;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int axil_data_width = 32;
    localparam int nbf_opcode_width = 8;
    localparam int nbf_addr_width = 64;
    localparam int nbf_data_width = 64;
    localparam int nbf_width = nbf_opcode_width + nbf_addr_width + nbf_data_width;
    localparam int nbf_beats = ceil_div(nbf_width, axil_data_width);

    typedef struct packed {
        logic [nbf_opcode_width-1:0] opcode;
        logic [nbf_addr_width-1:0]   addr;
        logic [nbf_data_width-1:0]   data;
    } nbf_cmd_s;

endpackage

// File: rtl/axil_credit_word_counter_clear_up.sv
// clear_up_counter: clearable up counter that wraps from max_val_p back to 0.
module clear_up_counter
    import axil_credit_pkg::*;
#(
    parameter int max_val_p  = nbf_beats,
    parameter int init_val_p = 0
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                clear_i,
    input  logic                                up_i,
    output logic [count_width(max_val_p+1)-1:0] count_o
);
    localparam int w = count_width(max_val_p + 1);

    logic [w-1:0] count_q;
    logic [w-1:0] count_d;
    logic [w-1:0] count_inc;

    assign count_inc = (count_q == w'(max_val_p)) ? '0 : count_q + w'(1);

    // Clear and up together means the clearing beat itself is counted.
    always_comb begin
        count_d = clear_i ? (up_i ? w'(1) : '0) : (up_i ? count_inc : count_q);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) count_q <= w'(init_val_p);
        else          count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/axil_credit_word_counter.sv
// axil_credit_word_counter: outstanding-write credit counter plus beat index counter.
// Define AXIL_CREDIT_COUNTER_ASSERT_EN to enable simulation checks for overflow/underflow.
module axil_credit_word_counter
    import axil_credit_pkg::*;
#(
    parameter int els_p       = 64,
    parameter int word_max_p  = nbf_beats,
    parameter int word_init_p = 0
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic                                 v_i,
    input  logic                                 ready_param_i,
    input  logic                                 yumi_i,
    output logic [count_width(els_p+1)-1:0]      credit_count_o,
    output logic                                 credits_full_o,
    output logic                                 credits_empty_o,
    input  logic                                 word_clear_i,
    input  logic                                 word_up_i,
    output logic [count_width(word_max_p+1)-1:0] word_count_o,
    output logic                                 word_last_o
);
    localparam int cw = count_width(els_p + 1);
    localparam int ww = count_width(word_max_p + 1);

    logic          inc;
    logic          dec;
    logic          full;
    logic          empty;
    logic [cw-1:0] credit_q;
    logic [cw-1:0] credit_d;

    assign inc   = v_i & ready_param_i;
    assign dec   = yumi_i;
    assign full  = credit_q == cw'(els_p);
    assign empty = credit_q == '0;

    // Illegal increments at full and decrements at empty are absorbed by holding.
    always_comb begin
        credit_d = (inc && !dec && !full)  ? credit_q + cw'(1) :
                   (dec && !inc && !empty) ? credit_q - cw'(1) : credit_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) credit_q <= '0;
        else          credit_q <= credit_d;
    end

    assign credit_count_o  = credit_q;
    assign credits_full_o  = full;
    assign credits_empty_o = empty;

    clear_up_counter #(
        .max_val_p (word_max_p),
        .init_val_p(word_init_p)
    ) word_cnt (
        .aclk   (aclk),
        .aresetn(aresetn),
        .clear_i(word_clear_i),
        .up_i   (word_up_i),
        .count_o(word_count_o)
    );

    assign word_last_o = word_count_o == ww'(word_max_p - 1);

`ifdef AXIL_CREDIT_COUNTER_ASSERT_EN
    always @(posedge aclk) begin
        if (aresetn) begin
            assert (!(inc && !dec && full)) else $error("credit overflow");
            assert (!(dec && !inc && empty)) else $error("credit underflow");
            assert (!(word_up_i && !word_clear_i && word_count_o == ww'(word_max_p)))
                else $error("word overflow");
        end
    end
`endif

endmodule

// File: tb/tb_axil_credit_word_counter.sv
// tb_axil_credit_word_counter: directed stimulus with a queued scoreboard checked after each edge.
module tb_axil_credit_word_counter;
    localparam int els = 4;
    localparam int wmax = 5;

    typedef struct {
        int cnt;
        int wcnt;
    } exp_t;

    logic       aclk = 0;
    logic       aresetn = 1;
    logic       v = 0, rdy = 0, yumi = 0, wclr = 0, wup = 0;
    logic [2:0] credit_count;
    logic       full, empty, wlast;
    logic [2:0] word_count;

    int total = 0;
    int bad = 0;
    exp_t q[$];

    axil_credit_word_counter #(.els_p(els), .word_max_p(wmax), .word_init_p(0)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .v_i            (v),
        .ready_param_i  (rdy),
        .yumi_i         (yumi),
        .credit_count_o (credit_count),
        .credits_full_o (full),
        .credits_empty_o(empty),
        .word_clear_i   (wclr),
        .word_up_i      (wup),
        .word_count_o   (word_count),
        .word_last_o    (wlast)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input int cnt, input int wcnt);
        chk("credit_count", int'(credit_count), cnt);
        chk("credits_full", int'(full), int'(cnt == els));
        chk("credits_empty", int'(empty), int'(cnt == 0));
        chk("word_count", int'(word_count), wcnt);
        chk("word_last", int'(wlast), int'(wcnt == wmax - 1));
    endtask

    task automatic step(input logic sv, input logic sr, input logic sy, input logic sc,
                        input logic su, input int cnt, input int wcnt);
        exp_t e;
        @(negedge aclk);
        v = sv; rdy = sr; yumi = sy; wclr = sc; wup = su;
        e.cnt = cnt;
        e.wcnt = wcnt;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge aclk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_all(e.cnt, e.wcnt);
            end
        end
    end

    initial begin
        #1 aresetn = 0;
        #1 check_all(0, 0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1;
        // fill to full, then overflow attempt and inc+dec at full
        step(1, 1, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 2, 0);
        step(1, 1, 0, 0, 0, 3, 0);
        step(1, 1, 0, 0, 0, 4, 0);
        step(1, 1, 0, 0, 0, 4, 0);
        step(1, 1, 1, 0, 0, 4, 0);
        step(0, 0, 1, 0, 0, 3, 0);
        step(0, 0, 1, 0, 0, 2, 0);
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0);
        // handshake qualification
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        // word sequence, clear, wrap
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 2);
        step(0, 0, 0, 0, 1, 0, 3);
        step(0, 0, 0, 0, 1, 0, 4);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 2);
        step(0, 0, 0, 0, 1, 0, 3);
        step(0, 0, 0, 0, 1, 0, 4);
        step(0, 0, 0, 0, 1, 0, 5);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 2);
        step(0, 0, 0, 0, 1, 0, 3);
        step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0);
        // both counters moving together
        step(1, 1, 0, 0, 1, 1, 1);
        step(1, 1, 0, 0, 1, 2, 2);
        step(0, 0, 0, 0, 0, 2, 2);
        // asynchronous reset mid-cycle with traffic applied
        @(negedge aclk);
        v = 1; rdy = 1; wup = 1;
        #2 aresetn = 0;
        #1 check_all(0, 0);
        step(1, 1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 1, 0, 0);
        @(negedge aclk);
        v = 0; rdy = 0; wup = 0;
        aresetn = 1;
        step(1, 1, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge aclk);
        #3;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
